// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD initiator.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEFAULT   = 16;
  localparam int unsigned GCD_TIMEOUT_DEFAULT = 65540;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_RESP
  } gcd_state_e;

endpackage

// File: rtl/gcd_driver_if.sv
// Request, core and response signals of the GCD initiator.
interface gcd_driver_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             gcd_clr;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data_in;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_err;

  // Driver side: owns the request-ready, the core controls and the response.
  modport master (
    input  req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    output req_ready, gcd_clr, gcd_start, gcd_data_in, rsp_valid, rsp_gcd, rsp_err
  );

  // Environment side: request source, GCD core and response consumer.
  modport slave (
    output req_valid, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    input  req_ready, gcd_clr, gcd_start, gcd_data_in, rsp_valid, rsp_gcd, rsp_err
  );

endinterface

// File: rtl/gcd_watchdog.sv
// Saturating run-time counter; flags the last allowed cycle of a core run.
module gcd_watchdog
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count up while enabled, hold at terminal count instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TC)) begin
      count <= count + CW'(1);
    end
  end

  assign tc_c = (count == TC);

endmodule

// File: rtl/gcd_driver.sv
// Sequences operand pairs into the serial GCD core and returns its result,
// bypassing the core for zero operands and aborting hung runs.
module gcd_driver
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = GCD_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  gcd_driver_if.master  bus
);

  gcd_state_e       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             wd_clr_c;
  logic             wd_en_c;
  logic             wd_tc_c;

  // Watchdog only runs in WAIT and restarts from zero on every entry.
  assign wd_en_c  = (state == ST_WAIT);
  assign wd_clr_c = (state != ST_WAIT);

  gcd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr_c),
    .en    (wd_en_c),
    .tc_c  (wd_tc_c)
  );

  // Request/core/response sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      a_q             <= '0;
      b_q             <= '0;
      bus.req_ready   <= 1'b0;
      bus.gcd_clr     <= 1'b1;
      bus.gcd_start   <= 1'b0;
      bus.gcd_data_in <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_gcd     <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      bus.gcd_clr   <= 1'b0;
      bus.gcd_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            a_q           <= bus.req_a;
            b_q           <= bus.req_b;
            if ((bus.req_a == '0) || (bus.req_b == '0)) begin
              // gcd(x,0) = x; both zero has no answer and is flagged.
              bus.rsp_valid <= 1'b1;
              bus.rsp_gcd   <= bus.req_a | bus.req_b;
              bus.rsp_err   <= (bus.req_a == '0) && (bus.req_b == '0);
              state         <= ST_RESP;
            end else begin
              bus.gcd_clr <= 1'b1;
              state       <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          bus.gcd_start   <= 1'b1;
          bus.gcd_data_in <= a_q;
          state           <= ST_LOAD_A;
        end
        ST_LOAD_A: begin
          bus.gcd_data_in <= b_q;
          state           <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          bus.gcd_data_in <= '0;
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done in the terminal-count cycle still counts as success.
          if (bus.gcd_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_gcd   <= bus.gcd_result;
            bus.rsp_err   <= 1'b0;
            state         <= ST_RESP;
          end else if (wd_tc_c) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_gcd   <= '0;
            bus.rsp_err   <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver: behavioural GCD cores on the serial side,
// a Euclid reference model and a per-cycle response scoreboard.
module tb_gcd_driver;
  import gcd_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned T1 = 8;

  typedef struct {
    logic [W-1:0] g;
    logic         e;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rsp_t q0[$];
  rsp_t q1[$];
  bit   hang1 = 1'b0;
  int   start_cnt0 = 0;
  int   clr_cnt0   = 0;

  always #5 clk = ~clk;

  gcd_driver_if #(.WIDTH(W)) d0 ();
  gcd_driver_if #(.WIDTH(W)) d1 ();

  gcd_driver #(.WIDTH(W)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d0)
  );

  gcd_driver #(.WIDTH(W), .TIMEOUT_CYCLES(T1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d1)
  );

  // Behavioural subtract-and-compare cores (core 1 can be made to hang).
  logic [W-1:0] ca0 = '0, cb0 = '0, ca1 = '0, cb1 = '0;
  int           ph0 = 0, ph1 = 0;
  logic         done0 = 1'b0, done1 = 1'b0;

  assign d0.gcd_done   = done0;
  assign d0.gcd_result = ca0;
  assign d1.gcd_done   = done1;
  assign d1.gcd_result = ca1;

  always @(posedge clk) begin
    if (d0.gcd_clr) begin
      ph0 <= 0; done0 <= 1'b0;
    end else if (ph0 == 0) begin
      if (d0.gcd_start) begin ca0 <= d0.gcd_data_in; ph0 <= 1; end
    end else if (ph0 == 1) begin
      cb0 <= d0.gcd_data_in; ph0 <= 2;
    end else if (!done0) begin
      if (ca0 == cb0)     done0 <= 1'b1;
      else if (ca0 > cb0) ca0 <= ca0 - cb0;
      else                cb0 <= cb0 - ca0;
    end
  end

  always @(posedge clk) begin
    if (d1.gcd_clr) begin
      ph1 <= 0; done1 <= 1'b0;
    end else if (ph1 == 0) begin
      if (d1.gcd_start) begin ca1 <= d1.gcd_data_in; ph1 <= 1; end
    end else if (ph1 == 1) begin
      cb1 <= d1.gcd_data_in; ph1 <= 2;
    end else if (!done1) begin
      if (ca1 == cb1)     done1 <= !hang1;
      else if (ca1 > cb1) ca1 <= ca1 - cb1;
      else                cb1 <= cb1 - ca1;
    end
  end

  always @(posedge clk) begin
    start_cnt0 <= start_cnt0 + int'(d0.gcd_start);
    clr_cnt0   <= clr_cnt0 + int'(d0.gcd_clr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the response must be for an accepted pair.
  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit hang);
    rsp_t r;
    int unsigned x, y, t;
    x = a; y = b;
    if (a == '0 || b == '0) begin
      r.g = a | b; r.e = (a == '0) && (b == '0);
    end else if (hang) begin
      r.g = '0; r.e = 1'b1;
    end else begin
      while (y != 0) begin t = x % y; x = y; y = t; end
      r.g = W'(x); r.e = 1'b0;
    end
    return r;
  endfunction

  task automatic score(input int inst, input logic v, input logic rr, input logic qr,
                       input logic [W-1:0] g, input logic e);
    rsp_t h;
    int   n;
    n = (inst == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        chk($sformatf("rsp%0d_unexpected", inst), 32'(v), 32'd0);
      end else begin
        h = (inst == 0) ? q0[0] : q1[0];
        chk($sformatf("rsp%0d_gcd", inst), 32'(g), 32'(h.g));
        chk($sformatf("rsp%0d_err", inst), 32'(e), 32'(h.e));
        chk($sformatf("rsp%0d_req_ready_busy", inst), 32'(qr), 32'd0);
        if (rr) begin
          if (inst == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end else if (n != 0) begin
      chk($sformatf("req%0d_ready_busy", inst), 32'(qr), 32'd0);
    end
  endtask

  // Scoreboard: every cycle with a pending or presented response.
  always @(negedge clk) begin
    if (rst_n) begin
      score(0, d0.rsp_valid, d0.rsp_ready, d0.req_ready, d0.rsp_gcd, d0.rsp_err);
      score(1, d1.rsp_valid, d1.rsp_ready, d1.req_ready, d1.rsp_gcd, d1.rsp_err);
    end
  end

  task automatic send(input int inst, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    if (inst == 0) begin d0.req_a = a; d0.req_b = b; d0.req_valid = 1'b1; end
    else           begin d1.req_a = a; d1.req_b = b; d1.req_valid = 1'b1; end
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = (inst == 0) ? d0.req_ready : d1.req_ready;
      @(posedge clk); #1;
    end
    d0.req_valid = 1'b0;
    d1.req_valid = 1'b0;
    if (!acc) chk($sformatf("accept%0d", inst), 32'(acc), 32'd1);
    else if (inst == 0) q0.push_back(model(a, b, 1'b0));
    else                q1.push_back(model(a, b, hang1));
  endtask

  task automatic wait_rsp(input int inst, input int start, input int budget, output int cyc);
    logic v;
    cyc = start;
    do begin
      @(negedge clk);
      cyc++;
      v = (inst == 0) ? d0.rsp_valid : d1.rsp_valid;
    end while (!v && cyc < budget);
    if (!v) chk($sformatf("rsp%0d_wait_timeout", inst), 32'(v), 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(d0.req_ready), 32'd0);
    chk({tag, "_gcd_clr"},   32'(d0.gcd_clr),   32'd1);
    chk({tag, "_gcd_start"}, 32'(d0.gcd_start), 32'd0);
    chk({tag, "_data_in"},   32'(d0.gcd_data_in), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(d0.rsp_valid), 32'd0);
    chk({tag, "_rsp_gcd"},   32'(d0.rsp_gcd),   32'd0);
    chk({tag, "_rsp_err"},   32'(d0.rsp_err),   32'd0);
    chk({tag, "_clr1"},      32'(d1.gcd_clr),   32'd1);
  endtask

  initial begin
    int cyc, sc, cc;
    d0.req_valid = 1'b0; d0.req_a = '0; d0.req_b = '0; d0.rsp_ready = 1'b1;
    d1.req_valid = 1'b0; d1.req_a = '0; d1.req_b = '0; d1.rsp_ready = 1'b1;

    // Reset values, then first cycle after release.
    #12;
    chk_reset_values("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_gcd_clr", 32'(d0.gcd_clr), 32'd0);
    chk("rel_req_ready", 32'(d0.req_ready), 32'd1);

    // Normal run: serial sequencing and result.
    send(0, 16'd48, 16'd18);
    @(negedge clk);
    chk("c1_clr", 32'(d0.gcd_clr), 32'd1);
    chk("c1_start", 32'(d0.gcd_start), 32'd0);
    @(negedge clk);
    chk("c2_start", 32'(d0.gcd_start), 32'd1);
    chk("c2_data", 32'(d0.gcd_data_in), 32'd48);
    chk("c2_clr", 32'(d0.gcd_clr), 32'd0);
    @(negedge clk);
    chk("c3_start", 32'(d0.gcd_start), 32'd0);
    chk("c3_data", 32'(d0.gcd_data_in), 32'd18);
    @(negedge clk);
    chk("c4_data", 32'(d0.gcd_data_in), 32'd0);
    wait_rsp(0, 4, 200, cyc);
    chk("norm_cycle", 32'(cyc), 32'd10);
    chk("norm_gcd", 32'(d0.rsp_gcd), 32'd6);
    chk("norm_err", 32'(d0.rsp_err), 32'd0);

    // Zero operands bypass the core.
    sc = start_cnt0; cc = clr_cnt0;
    send(0, 16'd0, 16'd35);
    @(negedge clk);
    chk("z35_valid", 32'(d0.rsp_valid), 32'd1);
    chk("z35_gcd", 32'(d0.rsp_gcd), 32'd35);
    chk("z35_err", 32'(d0.rsp_err), 32'd0);
    send(0, 16'd0, 16'd0);
    @(negedge clk);
    chk("z00_valid", 32'(d0.rsp_valid), 32'd1);
    chk("z00_gcd", 32'(d0.rsp_gcd), 32'd0);
    chk("z00_err", 32'(d0.rsp_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("zero_no_start", 32'(start_cnt0 - sc), 32'd0);
    chk("zero_no_clr", 32'(clr_cnt0 - cc), 32'd0);

    // Backpressure: response held stable while the consumer stalls.
    @(posedge clk); #1; d0.rsp_ready = 1'b0;
    send(0, 16'd21, 16'd14);
    wait_rsp(0, 1, 200, cyc);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(d0.rsp_valid), 32'd1);
      chk("bp_gcd", 32'(d0.rsp_gcd), 32'd7);
      chk("bp_req_ready", 32'(d0.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; d0.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(d0.rsp_valid), 32'd1);
    @(negedge clk);
    chk("bp_after_req_ready", 32'(d0.req_ready), 32'd1);
    chk("bp_after_valid", 32'(d0.rsp_valid), 32'd0);

    // Timeout on the short-watchdog instance, then a normal run there.
    hang1 = 1'b1;
    send(1, 16'd5, 16'd3);
    wait_rsp(1, 0, 100, cyc);
    chk("to_cycle", 32'(cyc), 32'(4 + T1));
    chk("to_gcd", 32'(d1.rsp_gcd), 32'd0);
    chk("to_err", 32'(d1.rsp_err), 32'd1);
    hang1 = 1'b0;
    send(1, 16'd9, 16'd6);
    wait_rsp(1, 0, 100, cyc);
    chk("after_to_gcd", 32'(d1.rsp_gcd), 32'd3);
    chk("after_to_err", 32'(d1.rsp_err), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    send(0, 16'd200, 16'd3);
    repeat (5) @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    q0.delete(); q1.delete();
    @(negedge clk);
    chk("midrst_clr_held", 32'(d0.gcd_clr), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrel_gcd_clr", 32'(d0.gcd_clr), 32'd0);
    chk("midrel_req_ready", 32'(d0.req_ready), 32'd1);
    send(0, 16'd35, 16'd14);
    wait_rsp(0, 0, 200, cyc);
    chk("post_rst_gcd", 32'(d0.rsp_gcd), 32'd7);

    // Longest convergence within the default watchdog, then back-to-back.
    send(0, 16'd65535, 16'd1);
    wait_rsp(0, 0, 70000, cyc);
    chk("worst_gcd", 32'(d0.rsp_gcd), 32'd1);
    chk("worst_err", 32'(d0.rsp_err), 32'd0);
    send(0, 16'd100, 16'd75);
    wait_rsp(0, 0, 200, cyc);
    chk("b2b_gcd", 32'(d0.rsp_gcd), 32'd25);
    chk("b2b_err", 32'(d0.rsp_err), 32'd0);

    repeat (3) @(negedge clk);
    chk("end_q0_drained", 32'(q0.size()), 32'd0);
    chk("end_q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_driver.md
# gcd_driver

Initiator for the subtract-and-compare GCD core. Accepts operand pairs on a valid/ready request port and sequences them into the core over its serial `start`/`data_in`/`done` interface: clear, load A, load B, wait. Returns the result on a valid/ready response port. Sits between the system request source and the GCD controller/datapath pair. It also short-circuits zero operands and bounds run time with a watchdog, because the core hangs on zero or non-converging inputs.

## Interface
- `WIDTH`, 16, operand/result width.
- `TIMEOUT_CYCLES`, 65540, maximum cycles in WAIT before abort; must be ≥ 2^WIDTH+4 for full-range operands.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  operand pair valid.
- `req_ready`  out  1  driver idle; request accepted when both are high.
- `req_a`, `req_b`  in  WIDTH  operands.
- `gcd_clr`  out  1  synchronous clear to core, returns it to its load-A state with `done`=0.
- `gcd_start`  out  1  core start strobe.
- `gcd_data_in`  out  WIDTH  serial operand bus to core.
- `gcd_done`  in  1  core finished; level, sticky until `gcd_clr`.
- `gcd_result`  in  WIDTH  core A-register value, valid when `gcd_done`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_gcd`  out  WIDTH  result.
- `rsp_err`  out  1  1 = timeout, or both operands zero.

## Operation
- States:
  - IDLE → CLEAR → LOAD_A → LOAD_B → WAIT → RESP → IDLE.
  - IDLE → RESP directly on a zero operand.
- **IDLE:** `req_ready`=1. On `req_valid`: latch `req_a`/`req_b`.
  - If a==0 or b==0, go to RESP with `rsp_gcd` = a|b.
  - `rsp_err`=1 only if both are zero (then `rsp_gcd`=0).
  - Otherwise go to CLEAR.
- **CLEAR:** `gcd_clr`=1 for one cycle.
- **LOAD_A:** `gcd_start`=1, `gcd_data_in`=A, one cycle.
- **LOAD_B:** `gcd_start`=0, `gcd_data_in`=B, one cycle.
- **WAIT:** `gcd_data_in`=0, watchdog counts from 0.
  - `gcd_done`=1: capture `gcd_result` into `rsp_gcd`, `rsp_err`=0, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES`-1 with `gcd_done` still 0: `rsp_gcd`=0, `rsp_err`=1, go to RESP.
  - If both conditions hold in the same cycle, done wins.
- **RESP:** `rsp_valid`=1. `rsp_gcd`/`rsp_err` are held stable until `rsp_ready`; then go to IDLE.
- `gcd_done` is ignored outside WAIT. A stale `done` from a previous run is removed by CLEAR.
- All outputs are registered.
- Reset values: `req_ready`=0, `gcd_clr`=1 (held throughout reset), `gcd_start`=0, `gcd_data_in`=0, `rsp_valid`=0, `rsp_gcd`=0, `rsp_err`=0, state=IDLE, watchdog=0.
- Reset mid-operation: any in-flight request or pending response is discarded without indication.

## Timing
- Accept edge = cycle 0. CLEAR = cycle 1, LOAD_A = cycle 2, LOAD_B = cycle 3, WAIT from cycle 4.
- `rsp_valid` rises on the edge after `gcd_done` is sampled high in WAIT.
- Zero-operand path: `rsp_valid`=1 in cycle 1. `gcd_clr`/`gcd_start` are never asserted.
- Timeout: `rsp_valid`=1 in cycle 4+`TIMEOUT_CYCLES`.
- `req_ready` drops on the accept edge. It rises again on the edge after `rsp_valid && rsp_ready`, so there is no same-cycle request overlap.
- First cycle after `rst_n` release: `gcd_clr`→0, `req_ready`→1.
- Watchdog width is $clog2(`TIMEOUT_CYCLES`). It saturates, never wraps.

## Structure
- `gcd_pkg`: state enum, `GCD_WIDTH_DEFAULT`=16, `GCD_TIMEOUT_DEFAULT`=65540.
- Sub-module `gcd_watchdog`: clear/enable counter with terminal-count output, parameterised by `TIMEOUT_CYCLES`.
- The top level holds the FSM and the operand/response registers.

## Test plan
- **Normal run:** req (48,18) with a behavioural core model.
  - Expect `gcd_clr` in cycle 1, `gcd_start`/`gcd_data_in`=48 in cycle 2, `gcd_data_in`=18 in cycle 3.
  - Expect `rsp_gcd`=6, `rsp_err`=0.
- **Zero operands:**
  - (0,35) → `rsp_gcd`=35, `rsp_err`=0 in cycle 1; `gcd_start` never high.
  - (0,0) → `rsp_gcd`=0, `rsp_err`=1.
- **Backpressure:** (21,14) with `rsp_ready` low for 5 cycles.
  - Expect `rsp_valid`=1 and `rsp_gcd`=7 stable throughout, `req_ready`=0.
  - After the handshake, `req_ready`=1 next cycle.
- **Timeout:** `TIMEOUT_CYCLES`=8, core model never asserts `done`.
  - Expect `rsp_valid` in cycle 12 with `rsp_err`=1, `rsp_gcd`=0.
  - Then (9,6) → 3.
- **Reset mid-WAIT:** assert `rst_n`=0 asynchronously.
  - Expect outputs at reset values immediately and `gcd_clr`=1 during reset.
  - After release, (35,14) → 7.
- **Worst case:** (65535,1) with default timeout → `rsp_gcd`=1, `rsp_err`=0. Then back-to-back (100,75) → 25.
